pwm_ctrl: RTL and testbench
===========================

# pwm_ctrl

Timebase and configuration controller for the PWM generator. Produces the free-running `count_val`, holds the active `period`, `compare1`, `compare2` and `functions` values, and drives `pwm_en` into `pwm_gen`. New settings arrive over a valid/ready handshake into shadow registers. While running, they are committed only at a period wrap, so a PWM cycle never uses a mix of old and new settings.

## Interface
Parameters:
- `CNT_W`, 16, width of counter, period and compare values
- `FUNC_W`, 8, width of the functions field
- `PRE_W`, 8, prescaler width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  run request; level sensitive
- `prescale`  in  PRE_W  counter advances every prescale+1 clocks; sampled live
- `cfg_valid`  in  1  new configuration offered
- `cfg_ready`  out  1  controller can accept a configuration
- `cfg_period`  in  CNT_W  new period
- `cfg_compare1`  in  CNT_W  new compare1
- `cfg_compare2`  in  CNT_W  new compare2
- `cfg_functions`  in  FUNC_W  new functions
- `pwm_en`  out  1  enable to the generator
- `count_val`  out  CNT_W  current count
- `period`, `compare1`, `compare2`  out  CNT_W  active values
- `functions`  out  FUNC_W  active value
- `period_end`  out  1  one-cycle pulse on each wrap
- `upd_done`  out  1  one-cycle pulse when shadow values are committed to the active registers

## Operation
- A handshake occurs when `cfg_valid && cfg_ready` at a rising edge; the `cfg_*` buses are captured into shadow registers on that edge.
- The prescaler counter `pre_cnt` increments every clock while running. A tick occurs when `pre_cnt >= prescale`, and `pre_cnt` returns to 0 on that tick. Using `>=` means a decrease of `prescale` never stalls the prescaler.
- On each tick, `count_val` increments, or wraps to 0 if `count_val >= period`. Using `>=` means a shrunk period wraps immediately. With `period == 0`, `count_val` stays 0 and a wrap occurs on every tick.
- The state machine has three states: IDLE, RUN and PEND.
  - IDLE: `pre_cnt` and `count_val` held at 0, `pwm_en` = 0, `cfg_ready` = 1. A handshake commits the shadow values to the active registers on the next edge and pulses `upd_done`. `en` = 1 moves to RUN.
  - RUN: counting, `cfg_ready` = 1. A handshake moves to PEND. `en` = 0 moves to IDLE and clears the counters.
  - PEND: counting, `cfg_ready` = 0. On the first wrap tick strictly after entry, the shadow values are committed in the same edge that zeroes `count_val`; `upd_done` and `period_end` pulse together and the state returns to RUN. `en` = 0 commits the shadow values immediately, pulses `upd_done` and moves to IDLE.
- Boundary cases:
  - Handshake in the same cycle as a RUN wrap: this wrap uses the old values; the commit happens at the next wrap.
  - `en` and `cfg_valid` both rising in IDLE: the commit and the move to RUN happen on the same edge; counting starts with the new values.

## Timing
- Reset values: state IDLE, all counters, active registers and shadow registers 0, `pwm_en` 0, `period_end` 0, `upd_done` 0, `cfg_ready` 1.
- Reset asserted mid-operation returns everything to the reset values asynchronously; a pending shadow value is discarded.
- `cfg_ready` is a combinational decode of the state.
- All other outputs are registered.
- `pwm_en` rises 1 clock after `en` is sampled high and falls 1 clock after `en` is sampled low.
- In RUN with `prescale` = P, consecutive `count_val` steps are P+1 clocks apart, and one full cycle lasts (period+1)·(P+1) clocks.
- `period_end` is high in the cycle in which `count_val` reads 0 after a wrap. It is not asserted on entry to RUN.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum `pwm_ctrl_state_t` (IDLE, RUN, PEND)
  - the constants `PWM_CNT_W` = 16 and `PWM_FUNC_W` = 8
  - the packed struct `pwm_cfg_t` {period, compare1, compare2, functions}, used for both the shadow and active register sets
- One sub-module, `pwm_prescaler`: it owns `pre_cnt`, has inputs `run` and `prescale`, and has output `tick`.
- The counter, state machine and register sets live in the top level.

## Test plan
- Reset then `en` = 1, `prescale` = 0, `period` = 3 → `count_val` runs 0,1,2,3,0; `period_end` pulses every 4 clocks; `pwm_en` high 1 clock after `en`.
- `prescale` = 2, `period` = 4 → each count value holds for 3 clocks; `period_end` pulses every 15 clocks.
- In RUN with `period` = 9, handshake `cfg_period` = 5, `cfg_compare1` = 2 when `count_val` = 3 → `cfg_ready` low until the wrap; the active values stay old until `count_val` returns to 0; then `upd_done` and `period_end` pulse together; the next wrap occurs after count 5.
- Handshake landing exactly on a wrap tick → commit deferred by one full period; `cfg_ready` stays low throughout.
- PEND with `en` dropped → immediate commit and `upd_done` pulse; `count_val` = 0 and `pwm_en` = 0 on the next clock; `cfg_ready` returns to 1.
- `rst_n` asserted while in PEND with a value of 7 in the shadow `period` → all outputs 0 and `cfg_ready` = 1 asynchronously; after release, the active `period` reads 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM controller and its timebase.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W  = 16;
    localparam int unsigned PWM_FUNC_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPend
    } pwm_ctrl_state_t;

    typedef struct packed {
        logic [PWM_CNT_W-1:0]  period;
        logic [PWM_CNT_W-1:0]  compare1;
        logic [PWM_CNT_W-1:0]  compare2;
        logic [PWM_FUNC_W-1:0] functions;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM timebase: one tick every prescale+1 clocks while running.
module pwm_prescaler #(
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    // >= keeps the divider from stalling when prescale shrinks below the current count
    always_comb begin
        tick      = run && (pre_cnt_q >= prescale);
        pre_cnt_d = '0;
        if (run) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// PWM timebase and configuration controller: free-running counter plus shadowed settings
// that are only committed at a period wrap while running.
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W  = PWM_CNT_W,
    parameter int unsigned FUNC_W = PWM_FUNC_W,
    parameter int unsigned PRE_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [PRE_W-1:0]  prescale,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_compare1,
    input  logic [CNT_W-1:0]  cfg_compare2,
    input  logic [FUNC_W-1:0] cfg_functions,
    output logic              pwm_en,
    output logic [CNT_W-1:0]  count_val,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  compare1,
    output logic [CNT_W-1:0]  compare2,
    output logic [FUNC_W-1:0] functions,
    output logic              period_end,
    output logic              upd_done
);

    pwm_ctrl_state_t  state_q, state_d;
    pwm_cfg_t         sh_q, sh_d;
    pwm_cfg_t         act_q, act_d;
    pwm_cfg_t         cfg_in;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pwm_en_q, pwm_en_d;
    logic             period_end_q, period_end_d;
    logic             upd_done_q, upd_done_d;
    logic             run, tick, hs, wrap;

    assign cfg_in = '{
        period:    PWM_CNT_W'(cfg_period),
        compare1:  PWM_CNT_W'(cfg_compare1),
        compare2:  PWM_CNT_W'(cfg_compare2),
        functions: PWM_FUNC_W'(cfg_functions)
    };

    // Dropping en clears the prescaler on the same edge that returns to idle
    assign run       = (state_q != StIdle) && en;
    assign cfg_ready = (state_q != StPend);
    assign hs        = cfg_valid && cfg_ready;
    assign wrap      = tick && (count_q >= CNT_W'(act_q.period));

    pwm_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        act_d        = act_q;
        count_d      = count_q;
        upd_done_d   = 1'b0;
        period_end_d = wrap;

        if (hs) begin
            sh_d = cfg_in;
        end
        if (tick) begin
            count_d = wrap ? '0 : count_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                count_d = '0;
                if (hs) begin
                    act_d      = cfg_in;
                    upd_done_d = 1'b1;
                end
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    // An offer accepted on the way out is committed rather than dropped
                    state_d = StIdle;
                    count_d = '0;
                    if (hs) begin
                        act_d      = cfg_in;
                        upd_done_d = 1'b1;
                    end
                end else if (hs) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (!en) begin
                    state_d    = StIdle;
                    count_d    = '0;
                    act_d      = sh_q;
                    upd_done_d = 1'b1;
                end else if (wrap) begin
                    state_d    = StRun;
                    act_d      = sh_q;
                    upd_done_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase

        pwm_en_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sh_q         <= '0;
            act_q        <= '0;
            count_q      <= '0;
            pwm_en_q     <= 1'b0;
            period_end_q <= 1'b0;
            upd_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            act_q        <= act_d;
            count_q      <= count_d;
            pwm_en_q     <= pwm_en_d;
            period_end_q <= period_end_d;
            upd_done_q   <= upd_done_d;
        end
    end

    assign pwm_en     = pwm_en_q;
    assign count_val  = count_q;
    assign period     = CNT_W'(act_q.period);
    assign compare1   = CNT_W'(act_q.compare1);
    assign compare2   = CNT_W'(act_q.compare2);
    assign functions  = FUNC_W'(act_q.functions);
    assign period_end = period_end_q;
    assign upd_done   = upd_done_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Self-checking bench for pwm_ctrl: directed scenarios against a cycle model plus literal checks.
module tb_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  prescale = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_compare1 = '0;
    logic [15:0] cfg_compare2 = '0;
    logic [7:0]  cfg_functions = '0;
    logic        pwm_en;
    logic [15:0] count_val, period, compare1, compare2;
    logic [7:0]  functions;
    logic        period_end, upd_done;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_ctrl #(
        .CNT_W  (16),
        .FUNC_W (8),
        .PRE_W  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .prescale      (prescale),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_compare1  (cfg_compare1),
        .cfg_compare2  (cfg_compare2),
        .cfg_functions (cfg_functions),
        .pwm_en        (pwm_en),
        .count_val     (count_val),
        .period        (period),
        .compare1      (compare1),
        .compare2      (compare2),
        .functions     (functions),
        .period_end    (period_end),
        .upd_done      (upd_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: running/pending flags, integer-style counters, two settings sets
    logic        m_running = 1'b0, m_pending = 1'b0;
    logic [7:0]  m_pre = '0;
    logic [15:0] m_cnt = '0;
    logic [15:0] m_per = '0, m_c1 = '0, m_c2 = '0;
    logic [7:0]  m_fn = '0;
    logic [15:0] s_per = '0, s_c1 = '0, s_c2 = '0;
    logic [7:0]  s_fn = '0;
    logic        m_pe = 1'b0, m_upd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 1'b0; m_pending = 1'b0; m_pre = '0; m_cnt = '0;
        m_per = '0; m_c1 = '0; m_c2 = '0; m_fn = '0;
        s_per = '0; s_c1 = '0; s_c2 = '0; s_fn = '0;
        m_pe = 1'b0; m_upd = 1'b0;
    endtask

    task automatic commit_shadow();
        m_per = s_per; m_c1 = s_c1; m_c2 = s_c2; m_fn = s_fn;
        m_upd = 1'b1;
    endtask

    task automatic model_step();
        logic hs, tck, wr;
        hs    = cfg_valid && !m_pending;
        m_upd = 1'b0;
        m_pe  = 1'b0;
        if (hs) begin
            s_per = cfg_period; s_c1 = cfg_compare1; s_c2 = cfg_compare2; s_fn = cfg_functions;
        end
        if (!m_running) begin
            if (hs) commit_shadow();
            m_running = en;
        end else if (!en) begin
            if (m_pending || hs) commit_shadow();
            m_running = 1'b0; m_pending = 1'b0; m_pre = '0; m_cnt = '0;
        end else begin
            tck   = (m_pre >= prescale);
            m_pre = tck ? 8'd0 : m_pre + 8'd1;
            wr    = tck && (m_cnt >= m_per);
            if (tck) m_cnt = wr ? 16'd0 : m_cnt + 16'd1;
            if (wr) begin
                m_pe = 1'b1;
                if (m_pending) begin
                    commit_shadow();
                    m_pending = 1'b0;
                end
            end
            if (hs) m_pending = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("m.count_val",  32'(count_val),  32'(m_cnt));
                chk("m.period",     32'(period),     32'(m_per));
                chk("m.compare1",   32'(compare1),   32'(m_c1));
                chk("m.compare2",   32'(compare2),   32'(m_c2));
                chk("m.functions",  32'(functions),  32'(m_fn));
                chk("m.pwm_en",     32'(pwm_en),     32'(m_running));
                chk("m.period_end", 32'(period_end), 32'(m_pe));
                chk("m.upd_done",   32'(upd_done),   32'(m_upd));
                chk("m.cfg_ready",  32'(cfg_ready),  32'(!m_pending));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic [15:0] p, input logic [15:0] c1,
                         input logic [15:0] c2, input logic [7:0] f);
        cfg_valid = v; cfg_period = p; cfg_compare1 = c1; cfg_compare2 = c2; cfg_functions = f;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".count_val"},  32'(count_val),  32'd0);
        chk({tag, ".period"},     32'(period),     32'd0);
        chk({tag, ".compare1"},   32'(compare1),   32'd0);
        chk({tag, ".functions"},  32'(functions),  32'd0);
        chk({tag, ".pwm_en"},     32'(pwm_en),     32'd0);
        chk({tag, ".period_end"}, 32'(period_end), 32'd0);
        chk({tag, ".upd_done"},   32'(upd_done),   32'd0);
        chk({tag, ".cfg_ready"},  32'(cfg_ready),  32'd1);
    endtask

    initial begin
        repeat (2) step();
        chk_zero_outputs("rst");
        #1 rst_n = 1'b1;

        // IDLE: en and cfg_valid together -> commit and start on one edge, period 3
        step();
        en = 1'b1;
        offer(1'b1, 16'd3, 16'd1, 16'd2, 8'h5a);
        step();
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        chk("t1.pwm_en",    32'(pwm_en),    32'd1);
        chk("t1.upd_done",  32'(upd_done),  32'd1);
        chk("t1.period",    32'(period),    32'd3);
        chk("t1.count0",    32'(count_val), 32'd0);
        chk("t1.pe_entry",  32'(period_end), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t1.count", 32'(count_val),  32'(i % 4));
            chk("t1.pe",    32'(period_end), 32'((i % 4) == 0));
        end

        // prescale 2, period 4: count holds 3 clocks, wrap every 15
        en = 1'b0;
        step();
        chk("t2.pwm_en_off", 32'(pwm_en),    32'd0);
        chk("t2.count_clr",  32'(count_val), 32'd0);
        offer(1'b1, 16'd4, 16'd2, 16'd3, 8'h01);
        step();
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        chk("t2.upd_idle", 32'(upd_done), 32'd1);
        chk("t2.period",   32'(period),   32'd4);
        prescale = 8'd2;
        en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            chk("t2.count", 32'(count_val),  32'((k / 3) % 5));
            chk("t2.pe",    32'(period_end), 32'(k != 0 && (k % 15) == 0));
        end

        // period 9, new settings offered at count 3 -> committed at the wrap
        en = 1'b0;
        step();
        prescale = 8'd0;
        en = 1'b1;
        offer(1'b1, 16'd9, 16'd7, 16'd3, 8'h01);
        step();
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        repeat (3) step();
        chk("t3.count3", 32'(count_val), 32'd3);
        offer(1'b1, 16'd5, 16'd2, 16'd4, 8'h02);
        step();
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        chk("t3.ready_low", 32'(cfg_ready), 32'd0);
        chk("t3.count4",    32'(count_val), 32'd4);
        chk("t3.old_c1",    32'(compare1),  32'd7);
        for (int j = 5; j <= 9; j++) begin
            step();
            chk("t3.count_old",  32'(count_val), 32'(j));
            chk("t3.period_old", 32'(period),    32'd9);
            chk("t3.ready_pend", 32'(cfg_ready), 32'd0);
        end
        step();
        chk("t3.wrap_count", 32'(count_val),  32'd0);
        chk("t3.wrap_pe",    32'(period_end), 32'd1);
        chk("t3.wrap_upd",   32'(upd_done),   32'd1);
        chk("t3.new_period", 32'(period),     32'd5);
        chk("t3.new_c1",     32'(compare1),   32'd2);
        chk("t3.ready_back", 32'(cfg_ready),  32'd1);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("t3.count_new", 32'(count_val),  32'(j % 6));
            chk("t3.pe_new",    32'(period_end), 32'(j == 6));
        end

        // Offer lands on a wrap tick -> commit deferred one full period
        repeat (5) step();
        chk("t4.count5", 32'(count_val), 32'd5);
        offer(1'b1, 16'd2, 16'd1, 16'd1, 8'h03);
        step();
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        chk("t4.pe_old",  32'(period_end), 32'd1);
        chk("t4.no_upd",  32'(upd_done),   32'd0);
        chk("t4.per_old", 32'(period),     32'd5);
        chk("t4.ready",   32'(cfg_ready),  32'd0);
        for (int j = 1; j <= 5; j++) begin
            step();
            chk("t4.count_pend", 32'(count_val), 32'(j));
            chk("t4.ready_pend", 32'(cfg_ready), 32'd0);
        end
        step();
        chk("t4.commit_upd", 32'(upd_done),   32'd1);
        chk("t4.commit_pe",  32'(period_end), 32'd1);
        chk("t4.commit_per", 32'(period),     32'd2);

        // PEND with en dropped -> immediate commit and idle
        offer(1'b1, 16'd7, 16'd3, 16'd6, 8'ha5);
        step();
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        chk("t5.ready_pend", 32'(cfg_ready), 32'd0);
        en = 1'b0;
        step();
        chk("t5.upd",    32'(upd_done),  32'd1);
        chk("t5.count",  32'(count_val), 32'd0);
        chk("t5.pwm_en", 32'(pwm_en),    32'd0);
        chk("t5.period", 32'(period),    32'd7);
        chk("t5.func",   32'(functions), 32'ha5);
        chk("t5.ready",  32'(cfg_ready), 32'd1);
        step();
        chk("t5.upd_once", 32'(upd_done), 32'd0);

        // Reset while pending with shadow period 7
        en = 1'b1;
        step();
        offer(1'b1, 16'd7, 16'd0, 16'd0, 8'h00);
        step();
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        chk("t6.ready_pend", 32'(cfg_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("t6.async");
        en = 1'b0;
        step();
        #1 rst_n = 1'b1;
        step();
        chk("t6.period", 32'(period),    32'd0);
        chk("t6.ready",  32'(cfg_ready), 32'd1);
        chk("t6.pwm_en", 32'(pwm_en),    32'd0);

        // Mixed traffic with live prescale changes, checked by the model only
        en = 1'b1;
        offer(1'b1, 16'd6, 16'd2, 16'd4, 8'h11);
        step();
        for (int i = 0; i < 120; i++) begin
            if (i % 7 == 0) prescale = 8'($urandom_range(0, 3));
            offer(i % 11 == 0, 16'($urandom_range(0, 8)), 16'($urandom_range(0, 8)),
                  16'($urandom_range(0, 8)), 8'($urandom));
            en = !(i >= 60 && i < 63);
            step();
        end
        offer(1'b0, 16'd0, 16'd0, 16'd0, 8'h00);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
